// File: rtl/shake_squeeze_streamer_pkg.sv
// Shared constants, state encoding and byte-enable helper for the SHAKE squeeze streamer.
package shake_pkg;
  localparam int RATE_BITS       = 1088;
  localparam int W_BITS          = 64;
  localparam int WORDS_PER_BLOCK = RATE_BITS / W_BITS;
  localparam int KEEP_MAX        = 64;

  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

  // Mask with the top n of nbytes lanes set (MSB lane carries the first byte).
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int n, input int nbytes);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (i < nbytes && i >= nbytes - n) m[i] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/shake_squeeze_streamer_if.sv
// Word stream carrying squeezed output bytes to the downstream consumer.
interface shake_squeeze_streamer_if #(parameter int W = 64);
  logic [W-1:0]   out_data;
  logic [W/8-1:0] out_keep;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (output out_data, out_keep, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_keep, out_valid, out_last, output out_ready);
endinterface

// File: rtl/shake_squeeze_streamer_block_buf.sv
// Current/pending rate-block pair: captures squeezed blocks, hands pending to current, flags drops.
module shake_block_buf
  import shake_pkg::*;
#(
  parameter int RATE = RATE_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RATE-1:0] i_hash,
  input  logic            i_load,
  input  logic            i_edge_emit,
  input  logic            i_advance,
  input  logic            i_flush,
  input  logic            i_clr_ovr,
  output logic [RATE-1:0] o_cur,
  output logic            o_pend_valid,
  output logic            o_overrun
);
  logic [RATE-1:0] r_cur;
  logic [RATE-1:0] r_pend;
  logic            r_pend_valid;
  logic            r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // An edge landing on an exhausted block with nothing pending feeds current directly.
      if (i_load || (i_advance && !r_pend_valid && i_edge_emit)) r_cur <= i_hash;
      else if (i_advance && r_pend_valid)                         r_cur <= r_pend;

      if (i_flush) begin
        r_pend_valid <= 1'b0;
      end else if (i_edge_emit) begin
        if (i_advance) begin
          if (r_pend_valid) r_pend <= i_hash;
        end else if (!r_pend_valid) begin
          r_pend       <= i_hash;
          r_pend_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (i_advance) begin
        r_pend_valid <= 1'b0;
      end

      if (i_clr_ovr) r_overrun <= 1'b0;
    end
  end

  assign o_cur        = r_cur;
  assign o_pend_valid = r_pend_valid;
  assign o_overrun    = r_overrun;
endmodule

// File: rtl/shake_squeeze_streamer.sv
// Captures SHAKE rate blocks on squeeze edges and streams a requested byte count as W-bit words.
module shake_squeeze_streamer
  import shake_pkg::*;
#(
  parameter int RATE  = RATE_BITS,
  parameter int W     = W_BITS,
  parameter int LEN_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          out_bytes,
  input  logic                      squeezed,
  input  logic [RATE-1:0]           hash,
  shake_squeeze_streamer_if.master  m_out,
  output logic                      active,
  output logic                      done,
  output logic                      overrun
);
  localparam int              WPB   = RATE / W;
  localparam int              IDX_W = $clog2(WPB);
  localparam int              BPW   = W / 8;
  localparam logic [LEN_W-1:0] BPW_L = LEN_W'(BPW);

  state_t            r_state;
  logic              r_sq_prev;
  logic [LEN_W-1:0]  r_rem;
  logic [IDX_W-1:0]  r_word_idx;
  logic              r_done;

  logic              w_sq_edge;
  logic              w_emit;
  logic              w_hs;
  logic              w_last;
  logic              w_exhaust;
  logic              w_start;
  logic              w_pend_valid;
  logic [RATE-1:0]   w_cur;
  logic [RATE-1:0]   w_cur_shift;
  logic [BPW-1:0]    w_keep_last;

  assign w_sq_edge = squeezed & ~r_sq_prev;
  assign w_emit    = (r_state == EMIT);
  assign w_hs      = w_emit & m_out.out_ready;
  assign w_last    = (r_rem <= BPW_L);
  assign w_exhaust = (r_word_idx == IDX_W'(WPB - 1));
  assign w_start   = start & (r_state == IDLE);

  shake_block_buf #(.RATE(RATE)) u_buf (
    .clk          (clock),
    .rst          (reset),
    .i_hash       (hash),
    .i_load       ((r_state == WAIT) & w_sq_edge),
    .i_edge_emit  (w_emit & w_sq_edge),
    .i_advance    (w_hs & ~w_last & w_exhaust),
    .i_flush      ((w_hs & w_last) | w_start),
    .i_clr_ovr    (w_start),
    .o_cur        (w_cur),
    .o_pend_valid (w_pend_valid),
    .o_overrun    (overrun)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sq_prev  <= 1'b1;
      r_rem      <= '0;
      r_word_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_sq_prev <= squeezed;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (out_bytes == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rem      <= out_bytes;
              r_word_idx <= '0;
              r_state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_sq_edge) begin
            r_word_idx <= '0;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (w_hs) begin
            if (w_last) begin
              r_rem   <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_rem <= r_rem - BPW_L;
              if (w_exhaust) begin
                r_word_idx <= '0;
                if (!(w_pend_valid || w_sq_edge)) r_state <= WAIT;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word 0 is the most significant W bits of the block.
  assign w_cur_shift = w_cur << (W * int'(r_word_idx));
  assign w_keep_last = BPW'(keep_mask(int'(r_rem), BPW));

  assign m_out.out_valid = w_emit;
  assign m_out.out_data  = w_emit ? w_cur_shift[RATE-1 -: W] : '0;
  assign m_out.out_keep  = w_emit ? (w_last ? w_keep_last : '1) : '0;
  assign m_out.out_last  = w_emit & w_last;
  assign active          = (r_state != IDLE);
  assign done            = r_done;
endmodule

// File: tb/tb_shake_squeeze_streamer.sv
// Scoreboard bench: requests are modelled as a byte stream cut from captured blocks into 8-byte words.
module tb_shake_squeeze_streamer;
  import shake_pkg::*;

  localparam int RATE  = 1088;
  localparam int W     = 64;
  localparam int LEN_W = 16;
  localparam int BPW   = W / 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] out_bytes = '0;
  logic             squeezed = 1'b0;
  logic [RATE-1:0]  hash = '0;
  logic             active, done, overrun;

  shake_squeeze_streamer_if #(.W(W)) s_if ();

  shake_squeeze_streamer #(.RATE(RATE), .W(W), .LEN_W(LEN_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .out_bytes (out_bytes),
    .squeezed  (squeezed),
    .hash      (hash),
    .m_out     (s_if),
    .active    (active),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [BPW-1:0] keep;
    logic           last;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    n_done = 0;
  int    exp_done = 0;
  int    m_rem = 0;
  bit    rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RATE-1:0] rand_block();
    logic [RATE-1:0] b;
    for (int i = 0; i < RATE / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Reference model: take up to one block's worth of the outstanding request, MSB byte first.
  task automatic push_block(input logic [RATE-1:0] blk);
    int    nb;
    int    b;
    word_t w;
    nb = (m_rem > RATE / 8) ? RATE / 8 : m_rem;
    for (int k = 0; nb > 0; k++) begin
      b      = (nb >= BPW) ? BPW : nb;
      w.data = blk[RATE-1-W*k -: W];
      w.keep = 8'(8'hFF << (BPW - b));
      nb    -= b;
      m_rem -= b;
      w.last = (m_rem == 0);
      exp_q.push_back(w);
    end
    if (m_rem == 0) exp_done++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input int n);
    tick();
    start     = 1'b1;
    out_bytes = LEN_W'(n);
    m_rem     = n;
    if (n == 0) exp_done++;
    tick();
    start = 1'b0;
  endtask

  task automatic squeeze(input logic [RATE-1:0] blk, input bit capture);
    tick();
    hash     = blk;
    squeezed = 1'b1;
    if (capture) push_block(blk);
    tick();
    squeezed = 1'b0;
    hash     = rand_block();
  endtask

  task automatic drain(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clock);
      c++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!s_if.out_valid && c < 20) begin
      @(negedge clock);
      c++;
    end
    check(name, 64'(s_if.out_valid), 64'd1);
  endtask

  // Monitor: pops on every handshake, checks hold-under-stall and the done pulse after a last word.
  initial begin
    word_t w;
    word_t prev_w;
    bit    prev_stall = 1'b0;
    bit    prev_last_hs = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clock);
      if (prev_last_hs) check("done_after_last", 64'(done), 64'd1);
      if (prev_stall && !reset) begin
        check("hold_valid", 64'(s_if.out_valid), 64'd1);
        check("hold_data", s_if.out_data, prev_w.data);
        check("hold_keep", 64'(s_if.out_keep), 64'(prev_w.keep));
      end
      prev_last_hs = 1'b0;
      prev_stall   = 1'b0;
      if (!reset && s_if.out_valid) begin
        if (s_if.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(s_if.out_data), 64'd0);
          end else begin
            w = exp_q.pop_front();
            check("word_data", s_if.out_data, w.data);
            check("word_keep", 64'(s_if.out_keep), 64'(w.keep));
            check("word_last", 64'(s_if.out_last), 64'(w.last));
            prev_last_hs = s_if.out_last;
          end
        end else begin
          prev_stall = 1'b1;
          prev_w     = '{data: s_if.out_data, keep: s_if.out_keep, last: s_if.out_last};
        end
      end
      if (done) n_done++;
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_rdy) s_if.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [RATE-1:0] kat;
    int              cnt;
    int              nd;
    s_if.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_valid", 64'(s_if.out_valid), 64'd0);
    check("rst_keep", 64'(s_if.out_keep), 64'd0);
    check("rst_last", 64'(s_if.out_last), 64'd0);
    check("rst_data", s_if.out_data, 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Empty-string SHAKE256 block, 32 bytes
    s_if.out_ready = 1'b1;
    start_req(32);
    check("t1_active", 64'(active), 64'd1);
    kat = rand_block();
    kat[RATE-1 -: 256] = 256'h46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762f;
    tick();
    hash     = kat;
    squeezed = 1'b1;
    push_block(kat);
    check("t1_valid_pre_edge", 64'(s_if.out_valid), 64'd0);
    tick();
    squeezed = 1'b0;
    check("t1_valid_lat1", 64'(s_if.out_valid), 64'd1);
    check("t1_word0", s_if.out_data, 64'h46b9dd2b0ba88d13);
    drain(100, "t1");
    check("t1_active_end", 64'(active), 64'd0);
    check("t1_done_count", 64'(n_done), 64'(exp_done));

    // Exactly one block
    start_req(136);
    squeeze(rand_block(), 1'b1);
    drain(100, "t2");
    check("t2_active_end", 64'(active), 64'd0);

    // Request spanning two blocks with an idle gap
    start_req(140);
    squeeze(rand_block(), 1'b1);
    drain(100, "t3a");
    cnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (s_if.out_valid) cnt++;
    end
    check("t3_gap_valid", 64'(cnt), 64'd0);
    check("t3_active_wait", 64'(active), 64'd1);
    squeeze(rand_block(), 1'b1);
    drain(100, "t3b");
    check("t3_done_count", 64'(n_done), 64'(exp_done));

    // Zero-length request
    start_req(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_active", 64'(active), 64'd0);
    tick();
    check("zero_done_pulse", 64'(done), 64'd0);

    // Backpressure mid-block
    s_if.out_ready = 1'b0;
    start_req(64);
    squeeze(rand_block(), 1'b1);
    wait_valid("t4_valid");
    tick();
    s_if.out_ready = 1'b1;
    repeat (2) tick();
    s_if.out_ready = 1'b0;
    repeat (5) tick();
    s_if.out_ready = 1'b1;
    drain(100, "t4");

    // Overrun: three edges while stalled
    s_if.out_ready = 1'b0;
    start_req(400);
    squeeze(rand_block(), 1'b1);
    squeeze(rand_block(), 1'b1);
    squeeze(rand_block(), 1'b0);
    tick();
    check("t5_overrun", 64'(overrun), 64'd1);
    s_if.out_ready = 1'b1;
    cnt = 0;
    repeat (34) begin
      @(negedge clock);
      if (!s_if.out_valid) cnt++;
    end
    check("t5_no_bubble", 64'(cnt), 64'd0);
    squeeze(rand_block(), 1'b1);
    drain(100, "t5");
    check("t5_overrun_sticky", 64'(overrun), 64'd1);
    check("t5_done_count", 64'(n_done), 64'(exp_done));

    // Randomized lengths with random backpressure
    rand_rdy = 1'b1;
    for (int it = 0; it < 4; it++) begin
      start_req(int'($urandom_range(1, 400)));
      if (it == 0) check("rand_overrun_clr", 64'(overrun), 64'd0);
      while (m_rem > 0) begin
        drain(400, "rand_mid");
        squeeze(rand_block(), 1'b1);
      end
      drain(400, "rand_end");
    end
    rand_rdy = 1'b0;
    tick();
    check("rand_done_count", 64'(n_done), 64'(exp_done));

    // Reset mid-stream with squeezed held high
    s_if.out_ready = 1'b0;
    start_req(200);
    squeeze(rand_block(), 1'b1);
    wait_valid("t7_valid");
    tick();
    s_if.out_ready = 1'b1;
    repeat (3) tick();
    nd             = n_done;
    reset          = 1'b1;
    squeezed       = 1'b1;
    s_if.out_ready = 1'b0;
    tick();
    check("t7_valid_after_rst", 64'(s_if.out_valid), 64'd0);
    check("t7_active_after_rst", 64'(active), 64'd0);
    exp_q.delete();
    m_rem = 0;
    exp_done = exp_done - 1;
    tick();
    reset          = 1'b0;
    s_if.out_ready = 1'b1;
    start_req(8);
    cnt = 0;
    repeat (5) begin
      tick();
      if (s_if.out_valid) cnt++;
    end
    check("t7_no_false_capture", 64'(cnt), 64'd0);
    squeezed = 1'b0;
    tick();
    squeeze(rand_block(), 1'b1);
    drain(100, "t7");
    check("t7_done_count", 64'(n_done), 64'(nd + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
